// File: rtl/pcie_tlp_tx.sv
// 16-bit MWr32/MRd32 TLP transmitter for the ECP3 PCIe user transmit port.
// One descriptor at a time: builds a 3DW header, appends the payload, streams 16-bit words.
module pcie_tlp_tx #(
    parameter int MAX_DW   = 4,
    parameter int TAG_BITS = 5
) (
    input  logic                  pcie_clk,
    input  logic                  sys_rst,
    input  logic [7:0]            bus_num,
    input  logic [4:0]            dev_num,
    input  logic [2:0]            func_num,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_rd,
    input  logic [29:0]           req_addr,
    input  logic [2:0]            req_len,
    input  logic [3:0]            req_first_be,
    input  logic [3:0]            req_last_be,
    input  logic [32*MAX_DW-1:0]  req_data,
    output logic                  tx_req,
    input  logic                  tx_rdy,
    output logic                  tx_st,
    output logic                  tx_end,
    output logic [15:0]           tx_data,
    output logic [TAG_BITS-1:0]   tag_out,
    output logic                  err_drop
);

    typedef enum logic [1:0] {IDLE, REQ, SEND} state_t;

    state_t                state_q, state_d;
    logic                  rd_q, rd_d;
    logic [29:0]           addr_q, addr_d;
    logic [2:0]            len_q, len_d;
    logic [3:0]            fbe_q, fbe_d;
    logic [3:0]            lbe_q, lbe_d;
    logic [32*MAX_DW-1:0]  data_q, data_d;
    logic [15:0]           rid_q, rid_d;
    logic [7:0]            htag_q, htag_d;
    logic [TAG_BITS-1:0]   tag_cnt_q, tag_cnt_d;
    logic [TAG_BITS-1:0]   tag_out_q, tag_out_d;
    logic [3:0]            idx_q, idx_d;
    logic                  req_ready_q, req_ready_d;
    logic                  tx_req_q, tx_req_d;
    logic                  tx_st_q, tx_st_d;
    logic                  tx_end_q, tx_end_d;
    logic [15:0]           tx_data_q, tx_data_d;
    logic                  err_drop_q, err_drop_d;

    logic                  len_ok;
    logic [3:0]            nxt_idx, last_idx, pay_idx;
    logic [32*MAX_DW-1:0]  dw_sh;
    logic [15:0]           word_nxt;

    assign len_ok = (req_len != 3'd0) && (int'(req_len) <= MAX_DW);

    // Word about to be presented: index 0 when leaving REQ, otherwise the one after idx_q.
    always_comb begin
        nxt_idx  = (state_q == REQ) ? 4'd0 : idx_q + 4'd1;
        last_idx = rd_q ? 4'd5 : 4'd5 + {len_q, 1'b0};
        pay_idx  = nxt_idx - 4'd6;
        dw_sh    = data_q >> {pay_idx[3:1], 5'b0};
        case (nxt_idx)
            4'd0:    word_nxt = {1'b0, ~rd_q, 1'b0, 5'b00000, 8'h00};
            4'd1:    word_nxt = {13'b0, len_q};
            4'd2:    word_nxt = rid_q;
            4'd3:    word_nxt = {htag_q, lbe_q, fbe_q};
            4'd4:    word_nxt = addr_q[29:14];
            4'd5:    word_nxt = {addr_q[13:0], 2'b00};
            default: word_nxt = pay_idx[0] ? dw_sh[15:0] : dw_sh[31:16];
        endcase
    end

    always_comb begin
        state_d     = state_q;
        rd_d        = rd_q;
        addr_d      = addr_q;
        len_d       = len_q;
        fbe_d       = fbe_q;
        lbe_d       = lbe_q;
        data_d      = data_q;
        rid_d       = rid_q;
        htag_d      = htag_q;
        tag_cnt_d   = tag_cnt_q;
        tag_out_d   = tag_out_q;
        idx_d       = idx_q;
        req_ready_d = req_ready_q;
        tx_req_d    = tx_req_q;
        tx_st_d     = tx_st_q;
        tx_end_d    = tx_end_q;
        tx_data_d   = tx_data_q;
        err_drop_d  = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid) begin
                    if (len_ok) begin
                        rd_d        = req_rd;
                        addr_d      = req_addr;
                        len_d       = req_len;
                        fbe_d       = req_first_be;
                        lbe_d       = (req_len == 3'd1) ? 4'h0 : req_last_be;
                        data_d      = req_data;
                        rid_d       = {bus_num, dev_num, func_num};
                        htag_d      = req_rd ? 8'(tag_cnt_q) : 8'h00;
                        state_d     = REQ;
                        tx_req_d    = 1'b1;
                        req_ready_d = 1'b0;
                        if (req_rd) begin
                            tag_out_d = tag_cnt_q;
                            tag_cnt_d = tag_cnt_q + 1'b1;
                        end
                    end else begin
                        err_drop_d = 1'b1;
                    end
                end
            end
            REQ: begin
                if (tx_rdy) begin
                    state_d   = SEND;
                    tx_req_d  = 1'b0;
                    idx_d     = 4'd0;
                    tx_data_d = word_nxt;
                    tx_st_d   = 1'b1;
                    tx_end_d  = 1'b0;
                end
            end
            SEND: begin
                if (tx_rdy) begin
                    if (idx_q == last_idx) begin
                        state_d     = IDLE;
                        tx_st_d     = 1'b0;
                        tx_end_d    = 1'b0;
                        tx_data_d   = 16'h0000;
                        req_ready_d = 1'b1;
                    end else begin
                        idx_d     = nxt_idx;
                        tx_data_d = word_nxt;
                        tx_st_d   = 1'b0;
                        tx_end_d  = (nxt_idx == last_idx);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pcie_clk) begin
        if (sys_rst) begin
            state_q     <= IDLE;
            rd_q        <= 1'b0;
            addr_q      <= '0;
            len_q       <= '0;
            fbe_q       <= '0;
            lbe_q       <= '0;
            data_q      <= '0;
            rid_q       <= '0;
            htag_q      <= '0;
            tag_cnt_q   <= '0;
            tag_out_q   <= '0;
            idx_q       <= '0;
            req_ready_q <= 1'b1;
            tx_req_q    <= 1'b0;
            tx_st_q     <= 1'b0;
            tx_end_q    <= 1'b0;
            tx_data_q   <= '0;
            err_drop_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_q        <= rd_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            fbe_q       <= fbe_d;
            lbe_q       <= lbe_d;
            data_q      <= data_d;
            rid_q       <= rid_d;
            htag_q      <= htag_d;
            tag_cnt_q   <= tag_cnt_d;
            tag_out_q   <= tag_out_d;
            idx_q       <= idx_d;
            req_ready_q <= req_ready_d;
            tx_req_q    <= tx_req_d;
            tx_st_q     <= tx_st_d;
            tx_end_q    <= tx_end_d;
            tx_data_q   <= tx_data_d;
            err_drop_q  <= err_drop_d;
        end
    end

    assign req_ready = req_ready_q;
    assign tx_req    = tx_req_q;
    assign tx_st     = tx_st_q;
    assign tx_end    = tx_end_q;
    assign tx_data   = tx_data_q;
    assign tag_out   = tag_out_q;
    assign err_drop  = err_drop_q;

endmodule

// File: tb/tb_pcie_tlp_tx.sv
// Bench for pcie_tlp_tx: directed and randomized descriptors checked against a word-list model.
module tb_pcie_tlp_tx;
    localparam int MAX_DW   = 4;
    localparam int TAG_BITS = 5;

    logic                 pcie_clk = 1'b0;
    logic                 sys_rst;
    logic [7:0]           bus_num;
    logic [4:0]           dev_num;
    logic [2:0]           func_num;
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_rd;
    logic [29:0]          req_addr;
    logic [2:0]           req_len;
    logic [3:0]           req_first_be;
    logic [3:0]           req_last_be;
    logic [32*MAX_DW-1:0] req_data;
    logic                 tx_req;
    logic                 tx_rdy;
    logic                 tx_st;
    logic                 tx_end;
    logic [15:0]          tx_data;
    logic [TAG_BITS-1:0]  tag_out;
    logic                 err_drop;

    pcie_tlp_tx #(.MAX_DW(MAX_DW), .TAG_BITS(TAG_BITS)) dut (
        .pcie_clk(pcie_clk), .sys_rst(sys_rst),
        .bus_num(bus_num), .dev_num(dev_num), .func_num(func_num),
        .req_valid(req_valid), .req_ready(req_ready), .req_rd(req_rd),
        .req_addr(req_addr), .req_len(req_len),
        .req_first_be(req_first_be), .req_last_be(req_last_be), .req_data(req_data),
        .tx_req(tx_req), .tx_rdy(tx_rdy), .tx_st(tx_st), .tx_end(tx_end),
        .tx_data(tx_data), .tag_out(tag_out), .err_drop(err_drop)
    );

    always #5 pcie_clk = ~pcie_clk;

    int          tests = 0;
    int          fails = 0;
    int          mtag = 0;
    int          last_tag = 0;
    int          hdr_tag = 0;
    logic [15:0] expq[$];
    logic [31:0] dws[MAX_DW];
    logic [7:0]  m_bus;
    logic [4:0]  m_dev;
    logic [2:0]  m_func;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected TLP as a list of 16-bit words, built from the field layout with plain arithmetic.
    task automatic build(input bit rd, input int dw_addr, input int len, input int fbe,
                         input int lbe, input int tag);
        int    lb;
        bit [31:0] ba;
        expq.delete();
        lb = (len == 1) ? 0 : lbe;
        ba = 32'(dw_addr) * 4;
        expq.push_back(rd ? 16'h0000 : 16'h4000);
        expq.push_back(16'(len));
        expq.push_back(16'(int'(m_bus) * 256 + int'(m_dev) * 8 + int'(m_func)));
        expq.push_back(16'(tag * 256 + lb * 16 + fbe));
        expq.push_back(16'(ba / 65536));
        expq.push_back(16'(ba % 65536));
        if (!rd)
            for (int k = 0; k < len; k++) begin
                expq.push_back(16'(dws[k] / 65536));
                expq.push_back(16'(dws[k] % 65536));
            end
    endtask

    task automatic scramble();
        req_rd       = 1'($urandom);
        req_addr     = 30'($urandom);
        req_len      = 3'($urandom);
        req_first_be = 4'($urandom);
        req_last_be  = 4'($urandom);
        req_data     = {$urandom, $urandom, $urandom, $urandom};
        bus_num      = 8'($urandom);
        dev_num      = 5'($urandom);
        func_num     = 3'($urandom);
    endtask

    // Present one descriptor for a single accept cycle (called at a negedge).
    task automatic issue(input bit rd, input int dw_addr, input int len, input int fbe,
                         input int lbe, input int bus, input int dev, input int func);
        bit legal;
        legal = (len >= 1) && (len <= MAX_DW);
        chk("ready_before", 32'(req_ready), 32'd1);
        m_bus = 8'(bus); m_dev = 5'(dev); m_func = 3'(func);
        bus_num = m_bus; dev_num = m_dev; func_num = m_func;
        req_rd = rd; req_addr = 30'(dw_addr); req_len = 3'(len);
        req_first_be = 4'(fbe); req_last_be = 4'(lbe);
        for (int k = 0; k < MAX_DW; k++) req_data[k*32 +: 32] = dws[k];
        req_valid = 1'b1;
        @(negedge pcie_clk);
        req_valid = 1'b0;
        scramble();
        if (legal) begin
            chk("tx_req_up", 32'(tx_req), 32'd1);
            chk("ready_low", 32'(req_ready), 32'd0);
            chk("no_err", 32'(err_drop), 32'd0);
            if (rd) begin
                hdr_tag = mtag; last_tag = mtag; mtag = (mtag + 1) % (1 << TAG_BITS);
            end else begin
                hdr_tag = 0;
            end
            chk("tag_out", 32'(tag_out), 32'(last_tag));
            build(rd, dw_addr, len, fbe, lbe, hdr_tag);
        end else begin
            chk("err_pulse", 32'(err_drop), 32'd1);
            chk("err_no_req", 32'(tx_req), 32'd0);
            chk("err_ready", 32'(req_ready), 32'd1);
            @(negedge pcie_clk);
            chk("err_one_cycle", 32'(err_drop), 32'd0);
            chk("err_no_req2", 32'(tx_req), 32'd0);
        end
    endtask

    // Consume the TLP: mode 0 = always ready, 1 = random stalls, 2 = stall 3 at word 2 and 1 at last.
    // stop_at >= 0 applies a reset while that word is presented and returns.
    task automatic stream(input int mode, input int stop_at);
        int  w = 0, cyc = 0, req_cyc = 0, guard = 0, last;
        bit  in_req = 1, done = 0, rdy;
        last = expq.size() - 1;
        while (!done && guard < 400) begin
            guard++;
            if (in_req) begin
                chk("req_hold", 32'(tx_req), 32'd1);
                chk("req_ready_low", 32'(req_ready), 32'd0);
                req_cyc++;
                rdy = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
                tx_rdy = rdy;
                @(negedge pcie_clk);
                if (rdy) in_req = 0;
            end else begin
                chk($sformatf("word%0d", w), 32'(tx_data), 32'(expq[w]));
                chk($sformatf("st%0d", w), 32'(tx_st), 32'(w == 0));
                chk($sformatf("end%0d", w), 32'(tx_end), 32'(w == last));
                chk("req_low", 32'(tx_req), 32'd0);
                if (w == stop_at) begin
                    sys_rst = 1'b1; tx_rdy = 1'b1;
                    @(negedge pcie_clk);
                    sys_rst = 1'b0; tx_rdy = 1'b0;
                    return;
                end
                case (mode)
                    0: rdy = 1'b1;
                    1: rdy = ($urandom_range(0, 2) != 0);
                    default: rdy = !((w == 2 && cyc < 3) || (w == last && cyc < 1));
                endcase
                tx_rdy = rdy;
                @(negedge pcie_clk);
                cyc++;
                if (rdy) begin
                    if (w == last) done = 1;
                    else begin w++; cyc = 0; end
                end
            end
        end
        tx_rdy = 1'b0;
        chk("no_timeout", 32'(done), 32'd1);
        chk("word_count", 32'(w + 1), 32'(expq.size()));
        if (mode == 0) chk("req_one_cycle", 32'(req_cyc), 32'd1);
        chk("idle_ready", 32'(req_ready), 32'd1);
        chk("idle_data", 32'(tx_data), 32'd0);
        chk("idle_st", 32'(tx_st), 32'd0);
        chk("idle_end", 32'(tx_end), 32'd0);
        chk("idle_req", 32'(tx_req), 32'd0);
    endtask

    task automatic chk_reset_vals();
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_req", 32'(tx_req), 32'd0);
        chk("rst_st", 32'(tx_st), 32'd0);
        chk("rst_end", 32'(tx_end), 32'd0);
        chk("rst_data", 32'(tx_data), 32'd0);
        chk("rst_tag", 32'(tag_out), 32'd0);
        chk("rst_err", 32'(err_drop), 32'd0);
        mtag = 0; last_tag = 0;
    endtask

    initial begin
        sys_rst = 1'b1; req_valid = 1'b0; tx_rdy = 1'b0;
        scramble();
        for (int k = 0; k < MAX_DW; k++) dws[k] = 32'h0;
        repeat (3) @(negedge pcie_clk);
        chk_reset_vals();
        sys_rst = 1'b0;
        @(negedge pcie_clk);

        // 1: MWr len 1, always ready
        dws[0] = 32'hDEADBEEF;
        issue(0, 32'h1000 / 4, 1, 4'hF, 4'hF, 8'h12, 1, 1);
        stream(0, -1);

        // 2: two back-to-back MRd len 2
        issue(1, 32'h80000040 / 4, 2, 4'hF, 4'hF, 8'h12, 1, 1);
        chk("mrd_w3_0", 32'(expq[3]), 32'h00FF);
        stream(0, -1);
        issue(1, 32'h80000040 / 4, 2, 4'hF, 4'hF, 8'h12, 1, 1);
        chk("tag_second", 32'(tag_out), 32'd1);
        stream(0, -1);

        // 3: MWr len 4 with stalls at word 2 and at the last word
        for (int k = 0; k < MAX_DW; k++) dws[k] = $urandom;
        issue(0, int'($urandom_range(0, 32'h3FFFFFFF)), 4, 4'h3, 4'hC, 8'hA5, 17, 6);
        stream(2, -1);
        chk("mwr_keeps_tag", 32'(tag_out), 32'd1);

        // 4: illegal lengths
        issue(0, 5, 0, 4'hF, 4'hF, 1, 2, 3);
        issue(1, 5, 5, 4'hF, 4'hF, 1, 2, 3);

        // 5: reset while word 3 is on the bus, then an MRd must carry tag 0
        issue(0, 32'h100, 3, 4'hF, 4'h1, 8'h33, 3, 2);
        stream(0, 3);
        chk_reset_vals();
        @(negedge pcie_clk);
        issue(1, 32'h2222, 1, 4'h1, 4'hF, 8'h44, 4, 4);
        chk("post_rst_hdr_tag", 32'(hdr_tag), 32'd0);
        stream(1, -1);

        // 6: tag wrap across 33 MRds from a clean counter
        sys_rst = 1'b1;
        @(negedge pcie_clk);
        sys_rst = 1'b0;
        chk_reset_vals();
        for (int i = 0; i < 33; i++) begin
            issue(1, int'($urandom_range(0, 32'h3FFFFFFF)), int'($urandom_range(1, MAX_DW)),
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 31)), int'($urandom_range(0, 7)));
            chk($sformatf("wrap_tag%0d", i), 32'(tag_out), 32'(i % 32));
            stream(1, -1);
        end

        // Random mix of MWr/MRd/illegal with random back-pressure
        for (int i = 0; i < 24; i++) begin
            int len;
            for (int k = 0; k < MAX_DW; k++) dws[k] = $urandom;
            len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(5, 7)) : int'($urandom_range(1, MAX_DW));
            issue(1'($urandom), int'($urandom_range(0, 32'h3FFFFFFF)), len,
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 31)), int'($urandom_range(0, 7)));
            if (len <= MAX_DW) stream(1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pcie_tlp_tx.md
Name: pcie_tlp_tx

Overview:
- 16-bit TLP transmitter for the ECP3 PCIe hard-core user transmit port (tx_req/tx_rdy/tx_st/tx_end/tx_data).
- Accepts one memory request descriptor at a time, either a 32-bit-address memory write (MWr) or a memory read (MRd). Builds a 3DW header, appends the write payload, and streams the result to the core.
- It is the transmit counterpart of the TLP receive path inside ipnuma. It is the source that remote-memory writes and reads leave through.

Parameters:
MAX_DW, 4, maximum payload / read length in DW; req_data is 32*MAX_DW bits
TAG_BITS, 5, width of the MRd tag counter; the tag field is zero-extended to 8 bits

Ports:
pcie_clk  in  1  clock
sys_rst  in  1  synchronous active-high reset
bus_num  in  8  requester bus number
dev_num  in  5  requester device number
func_num  in  3  requester function number
req_valid  in  1  descriptor valid
req_ready  out  1  block can accept a descriptor
req_rd  in  1  0 = MWr32, 1 = MRd32
req_addr  in  30  DW address, i.e. byte address [31:2]
req_len  in  3  length in DW; legal range 1..MAX_DW
req_first_be  in  4  first DW byte enables
req_last_be  in  4  last DW byte enables; forced to 0 when req_len = 1
req_data  in  32*MAX_DW  payload; DW0 = [31:0]
tx_req  out  1  request to the core
tx_rdy  in  1  core ready / word accept
tx_st  out  1  first word of TLP
tx_end  out  1  last word of TLP
tx_data  out  16  TLP word
tag_out  out  TAG_BITS  tag used by the most recent MRd
err_drop  out  1  one-cycle pulse when an illegal descriptor is dropped

Behaviour:
- Reset values: req_ready = 1, tx_req = 0, tx_st = 0, tx_end = 0, tx_data = 0, tag_out = 0, err_drop = 0. Tag counter = 0, state = IDLE.
- A reset in any state aborts the TLP in progress and returns the block to IDLE on the next edge.
- States: IDLE, REQ, SEND.
- IDLE: req_ready = 1.
  - On req_valid, the descriptor and bus/dev/func are latched.
  - Legal req_len: go to REQ next cycle.
  - req_len = 0 or req_len > MAX_DW: stay in IDLE and pulse err_drop for one cycle.
- REQ: tx_req = 1, req_ready = 0. On the first cycle tx_rdy = 1, go to SEND. In that same transition cycle tx_req drops and word 0 is presented with tx_st = 1.
- SEND: tx_data presents word n.
  - A word is consumed on a cycle with tx_rdy = 1; n then advances.
  - While tx_rdy = 0 the outputs hold.
  - tx_st = 1 only while word 0 is presented; tx_end = 1 only while the last word is presented.
  - When the last word is consumed: go to IDLE, clear tx_st, tx_end and tx_data, and raise req_ready.
- Minimum gap between TLPs is one IDLE cycle.
- Word count: MRd = 6 words; MWr = 6 + 2*req_len words.
- Header words, in order:
  - W0 = {1'b0, fmt[1:0], type 5'b00000, 8'h00}. fmt = 2'b10 for MWr (0x4000), 2'b00 for MRd (0x0000). TC, TD, EP and attr are all 0.
  - W1 = {6'b0, length[9:0]}, with length = req_len.
  - W2 = requester ID {bus, dev, func}.
  - W3 = {tag[7:0], last_be, first_be}. Tag is 0 for MWr and the counter value for MRd.
  - W4 = addr[31:16].
  - W5 = {addr[15:2], 2'b00}.
- Payload: DW k is sent upper halfword first, then lower halfword.
- Tag:
  - On entering REQ with an MRd, tag_out is loaded with the counter value and the counter increments. It wraps at 2^TAG_BITS.
  - MWr does not touch the counter.
- Descriptor inputs are don't-care outside the IDLE accept cycle. Changing req_* mid-TLP has no effect.

Test Plan:
1. Reset, bus 0x12, dev 1, func 1, MWr len 1, addr byte 0x00001000, data 0xDEADBEEF, first_be F, tx_rdy held 1 -> tx_req for 1 cycle, then 8 words 4000,0001,1209,000F,0000,1000,DEAD,BEEF. tx_st on word 0, tx_end on word 7, req_ready back to 1 after.
2. MRd len 2, addr 0x80000040, BE F/F, twice back-to-back -> first TLP words 0000,0002,1209,00FF,8000,0040 with tx_end on word 5. Second TLP W3 = 01FF. tag_out = 0 then 1.
3. MWr len 4 with tx_rdy deasserted for 3 cycles after word 2 and for 1 cycle at the last word -> word 2 and the last word hold, tx_end is held. Total 14 words delivered in order with no duplication.
4. Descriptor with req_len = 0, then req_len = 5 -> err_drop pulses once each, tx_req never asserts, req_ready stays 1.
5. sys_rst asserted while in SEND at word 3 -> next cycle all outputs are at reset values and the tag counter is 0. A following MRd carries tag 0.
6. 32 MRds with TAG_BITS = 5 -> tags 0..31, and the 33rd MRd carries tag 0 (wrap).
